// File: rtl/pipe_stall_ctrl.sv
// Stall/flush scheduler for the F_D, D_E, E_M and M_W pipeline registers.
// Optional stall-cycle performance counter enabled by defining PIPE_STALL_CTRL_PERF_EN.
module pipe_stall_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hz_stall,
  input  logic        E_md_start,
  input  logic        E_md_div,
  input  logic        D_md_use,
  input  logic        req,
  output logic        pc_en,
  output logic        FD_en,
  output logic        DE_stall,
  output logic        pipe_req,
  output logic        md_busy,
  output logic [3:0]  md_cnt,
  output logic [31:0] stall_cnt,
  output logic [1:0]  dbg_state
);

  if (MULT_CYC < 1 || MULT_CYC > 15) begin : g_bad_mult
    $error("MULT_CYC must be in 1..15");
  end
  if (DIV_CYC < 1 || DIV_CYC > 15) begin : g_bad_div
    $error("DIV_CYC must be in 1..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

  state_e     state_q, state_d;
  logic [3:0] md_cnt_q, md_cnt_d;
  logic       md_stall;
  logic       stall;

  // A start flushed by a same-cycle exception never launches the MDU.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (E_md_start && !req) begin
          if (E_md_div) begin
            state_d  = ST_DIV;
            md_cnt_d = DIV_LOAD;
          end else begin
            state_d  = ST_MULT;
            md_cnt_d = MULT_LOAD;
          end
        end
      end
      ST_MULT, ST_DIV: begin
        if (md_cnt_q <= 4'd1) begin
          state_d  = ST_IDLE;
          md_cnt_d = 4'd0;
        end else begin
          md_cnt_d = md_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        md_cnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      md_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // The issue cycle already counts as busy so a dependent D instr never slips past.
  assign md_busy   = (state_q != ST_IDLE) | E_md_start;
  assign md_stall  = D_md_use & md_busy;
  assign stall     = (hz_stall | md_stall) & ~req;

  assign pc_en     = ~stall;
  assign FD_en     = ~stall;
  assign DE_stall  = stall;
  assign pipe_req  = req;
  assign md_cnt    = md_cnt_q;
  assign dbg_state = state_q;

`ifdef PIPE_STALL_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= 32'd0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
